// File: rtl/hwreg_pkg.sv
// Shared constants for the hardware-register responder: register indices,
// byte offsets, STATUS / IRQ_MASK bit positions and the default ID value.
// The same values are mirrored into software headers.
package hwreg_pkg;

   // Register word indices
   localparam logic [3:0] IDX_ID             = 4'd0;
   localparam logic [3:0] IDX_FRAME_FLAG     = 4'd1;
   localparam logic [3:0] IDX_FRAME_FLAG_CLR = 4'd2;
   localparam logic [3:0] IDX_FRAME_COUNT    = 4'd3;
   localparam logic [3:0] IDX_TIMER          = 4'd4;
   localparam logic [3:0] IDX_TIMER_CMP      = 4'd5;
   localparam logic [3:0] IDX_STATUS         = 4'd6;
   localparam logic [3:0] IDX_FIFO_DATA      = 4'd7;
   localparam logic [3:0] IDX_IRQ_MASK       = 4'd8;

   // Register byte offsets
   localparam logic [7:0] OFS_ID             = 8'h00;
   localparam logic [7:0] OFS_FRAME_FLAG     = 8'h04;
   localparam logic [7:0] OFS_FRAME_FLAG_CLR = 8'h08;
   localparam logic [7:0] OFS_FRAME_COUNT    = 8'h0C;
   localparam logic [7:0] OFS_TIMER          = 8'h10;
   localparam logic [7:0] OFS_TIMER_CMP      = 8'h14;
   localparam logic [7:0] OFS_STATUS         = 8'h18;
   localparam logic [7:0] OFS_FIFO_DATA      = 8'h1C;
   localparam logic [7:0] OFS_IRQ_MASK       = 8'h20;

   // STATUS bit positions
   localparam int unsigned STS_EMPTY     = 32'd0;
   localparam int unsigned STS_FULL      = 32'd1;
   localparam int unsigned STS_OVERFLOW  = 32'd2;
   localparam int unsigned STS_TMATCH    = 32'd3;
   localparam int unsigned STS_COUNT_LSB = 32'd8;
   localparam int unsigned STS_COUNT_W   = 32'd8;

   // IRQ_MASK bit positions
   localparam int unsigned IRQ_FRAME    = 32'd0;
   localparam int unsigned IRQ_NONEMPTY = 32'd1;
   localparam int unsigned IRQ_TMATCH   = 32'd2;
   localparam int unsigned IRQ_MASK_W   = 32'd3;

   localparam logic [31:0] HW_ID_DEFAULT = 32'h4953_4C45;

endpackage

// File: rtl/hwreg_resp_fifo_sync.sv
// Small synchronous FIFO with occupancy count. Head entry is presented
// combinationally on dout; full is registered alongside the count.
// Pops on an empty FIFO and pushes on a full FIFO without a pop are ignored.
module fifo_sync #(
   parameter int DEPTH = 32'd16,
   parameter int W     = 32'd8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          full_r;
   logic          do_push_s;
   logic          do_pop_s;
   logic [CW-1:0] count_next_s;

   // Qualify push/pop and compute the next occupancy
   always_comb begin
      do_pop_s     = pop & (count_r != '0);
      do_push_s    = push & (~full_r | do_pop_s);
      count_next_s = count_r;
      case ({do_push_s, do_pop_s})
         2'b10:   count_next_s = count_r + CW'(1'b1);
         2'b01:   count_next_s = count_r - CW'(1'b1);
         default: count_next_s = count_r;
      endcase
   end

   // Pointer, count and full-flag state
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         full_r   <= 1'b0;
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         count_r <= count_next_s;
         full_r  <= (count_next_s == CW'(DEPTH));
      end
   end

   // Storage array, written on accepted pushes only
   always_ff @(posedge clk) begin
      if (do_push_s) mem_r[wr_ptr_r] <= din;
   end

   assign dout  = mem_r[rd_ptr_r];
   assign empty = (count_r == '0);
   assign full  = full_r;
   assign count = count_r;

endmodule

// File: rtl/hwreg_resp.sv
// Hardware-register responder on the CPU IO bus: frame flag and counter,
// free-running timer with compare, and a polled 8-bit input FIFO.
// Optional build macro HWREG_IRQ_EN adds the IRQ_MASK register and irq output.
module hwreg_resp
   import hwreg_pkg::*;
#(
   parameter int              WORD       = 32'd32,
   parameter int              BYTE_CNT   = 32'd4,
   parameter int              REGW       = 32'd4,
   parameter int              FIFO_DEPTH = 32'd16,
   parameter int              FIFO_W     = 32'd8,
   parameter logic [WORD-1:0] HW_ID      = HW_ID_DEFAULT
) (
   input  logic                clk_sys,
   input  logic                rst_sys,
   input  logic                cs,
   input  logic [REGW-1:0]     addr,
   input  logic [WORD-1:0]     wdata,
   input  logic [BYTE_CNT-1:0] wstrb,
   input  logic                rstrb,
   output logic [WORD-1:0]     rdata,
   output logic                rbusy,
   output logic                wbusy,
   input  logic                frame_start_sys,
   input  logic [FIFO_W-1:0]   fifo_din,
   input  logic                fifo_push,
   output logic                fifo_full
`ifdef HWREG_IRQ_EN
   ,
   output logic                irq
`endif
);

   localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;

   logic               rd_fire_s;
   logic               wr_fire_s;
   logic               fifo_pop_s;
   logic               match_set_s;
   logic               ovf_set_s;
   logic [WORD-1:0]    status_s;
   logic [WORD-1:0]    rd_mux_s;
   logic [FIFO_W-1:0]  fifo_dout_s;
   logic               fifo_empty_s;
   logic               fifo_full_s;
   logic [FIFO_CW-1:0] fifo_count_s;

   logic               frame_flag_r;
   logic [WORD-1:0]    frame_count_r;
   logic [WORD-1:0]    timer_r;
   logic [WORD-1:0]    timer_cmp_r;
   logic               overflow_r;
   logic               match_r;
   logic [WORD-1:0]    rdata_r;

   assign rd_fire_s   = cs & rstrb;
   assign wr_fire_s   = cs & (&wstrb);
   assign fifo_pop_s  = rd_fire_s & (addr == IDX_FIFO_DATA) & ~fifo_empty_s;
   assign match_set_s = (timer_r == timer_cmp_r);
   assign ovf_set_s   = fifo_push & fifo_full_s & ~fifo_pop_s;

   fifo_sync #(
      .DEPTH (FIFO_DEPTH),
      .W     (FIFO_W)
   ) u_fifo (
      .clk   (clk_sys),
      .rst   (rst_sys),
      .push  (fifo_push),
      .pop   (fifo_pop_s),
      .din   (fifo_din),
      .dout  (fifo_dout_s),
      .empty (fifo_empty_s),
      .full  (fifo_full_s),
      .count (fifo_count_s)
   );

   // Assemble the STATUS word from FIFO state and sticky bits
   always_comb begin
      status_s = '0;
      status_s[STS_EMPTY]    = fifo_empty_s;
      status_s[STS_FULL]     = fifo_full_s;
      status_s[STS_OVERFLOW] = overflow_r;
      status_s[STS_TMATCH]   = match_r;
      status_s[STS_COUNT_LSB +: STS_COUNT_W] = STS_COUNT_W'(fifo_count_s);
   end

   // Frame flag: set by the pulse, cleared by any full write to the clear slot
   always_ff @(posedge clk_sys) begin
      if (rst_sys)                                          frame_flag_r <= 1'b0;
      else if (frame_start_sys)                             frame_flag_r <= 1'b1;
      else if (wr_fire_s && addr == IDX_FRAME_FLAG_CLR)     frame_flag_r <= 1'b0;
   end

   // Frame counter: a write clears it, a coincident pulse still counts
   always_ff @(posedge clk_sys) begin
      if (rst_sys)
         frame_count_r <= '0;
      else if (wr_fire_s && addr == IDX_FRAME_COUNT)
         frame_count_r <= frame_start_sys ? WORD'(1'b1) : '0;
      else if (frame_start_sys)
         frame_count_r <= frame_count_r + WORD'(1'b1);
   end

   // Timer and compare value; a timer write reloads and counting resumes after
   always_ff @(posedge clk_sys) begin
      if (rst_sys) begin
         timer_r     <= '0;
         timer_cmp_r <= '1;
      end else begin
         if (wr_fire_s && addr == IDX_TIMER) timer_r <= wdata;
         else                                timer_r <= timer_r + WORD'(1'b1);
         if (wr_fire_s && addr == IDX_TIMER_CMP) timer_cmp_r <= wdata;
      end
   end

   // Sticky STATUS bits: set events beat a same-cycle write-1-to-clear
   always_ff @(posedge clk_sys) begin
      if (rst_sys) begin
         overflow_r <= 1'b0;
         match_r    <= 1'b0;
      end else begin
         if (ovf_set_s)
            overflow_r <= 1'b1;
         else if (wr_fire_s && addr == IDX_STATUS && wdata[STS_OVERFLOW])
            overflow_r <= 1'b0;
         if (match_set_s)
            match_r <= 1'b1;
         else if (wr_fire_s && addr == IDX_STATUS && wdata[STS_TMATCH])
            match_r <= 1'b0;
      end
   end

`ifdef HWREG_IRQ_EN
   logic [IRQ_MASK_W-1:0] irq_mask_r;
   logic [IRQ_MASK_W-1:0] irq_src_s;
   logic                  irq_r;

   // Gather interrupt sources in IRQ_MASK bit order
   always_comb begin
      irq_src_s               = '0;
      irq_src_s[IRQ_FRAME]    = frame_flag_r;
      irq_src_s[IRQ_NONEMPTY] = ~fifo_empty_s;
      irq_src_s[IRQ_TMATCH]   = match_r;
   end

   // Mask register and registered interrupt output
   always_ff @(posedge clk_sys) begin
      if (rst_sys) begin
         irq_mask_r <= '0;
         irq_r      <= 1'b0;
      end else begin
         if (wr_fire_s && addr == IDX_IRQ_MASK) irq_mask_r <= wdata[IRQ_MASK_W-1:0];
         irq_r <= |(irq_mask_r & irq_src_s);
      end
   end

   assign irq = irq_r;
`endif

   // Read mux over current register values; unmapped slots read zero
   always_comb begin
      rd_mux_s = '0;
      case (addr)
         IDX_ID:          rd_mux_s = HW_ID;
         IDX_FRAME_FLAG:  rd_mux_s = {{(WORD-1){1'b0}}, frame_flag_r};
         IDX_FRAME_COUNT: rd_mux_s = frame_count_r;
         IDX_TIMER:       rd_mux_s = timer_r;
         IDX_TIMER_CMP:   rd_mux_s = timer_cmp_r;
         IDX_STATUS:      rd_mux_s = status_s;
         IDX_FIFO_DATA: begin
            if (!fifo_empty_s) begin
               rd_mux_s[WORD-1]     = 1'b1;
               rd_mux_s[FIFO_W-1:0] = fifo_dout_s;
            end else begin
               rd_mux_s = '0;
            end
         end
`ifdef HWREG_IRQ_EN
         IDX_IRQ_MASK:    rd_mux_s = {{(WORD-IRQ_MASK_W){1'b0}}, irq_mask_r};
`endif
         default:         rd_mux_s = '0;
      endcase
   end

   // Read data register: captured on a read strobe, held otherwise
   always_ff @(posedge clk_sys) begin
      if (rst_sys)        rdata_r <= '0;
      else if (rd_fire_s) rdata_r <= rd_mux_s;
   end

   assign rdata     = rdata_r;
   assign rbusy     = 1'b0;
   assign wbusy     = 1'b0;
   assign fifo_full = fifo_full_s;

endmodule

// File: doc/hwreg_resp.md
Name: hwreg_resp

Overview:
- Memory-mapped hardware-register responder on the CPU IO bus (FemtoRV32 mem_* protocol: word address, wmask strobes, rstrb, read data one cycle later).
- Holds the frame flag, a frame counter, a cycle timer with compare, and an 8-bit input FIFO that the CPU drains by polling.
- Sits behind the top-level hwreg_cs decode, in the system clock domain. It replaces the inline hardware-register logic in the top level.

Parameters:
- WORD, 32, machine word width (bits)
- BYTE_CNT, 4, byte strobes per word
- REGW, 4, register index width (word-addressed, 16 slots)
- FIFO_DEPTH, 16, input FIFO entries (power of two)
- FIFO_W, 8, FIFO data width (bits)
- HW_ID, 'h49534C45, value returned by the ID register

Ports:
- clk_sys  in  1  system clock
- rst_sys  in  1  synchronous reset, active high
- cs  in  1  chip select (hwreg window decoded by top level)
- addr  in  REGW  register word index (io_addr[REGW-1:0])
- wdata  in  WORD  write data
- wstrb  in  BYTE_CNT  byte write strobes
- rstrb  in  1  read strobe
- rdata  out  WORD  registered read data
- rbusy  out  1  read busy, always 0
- wbusy  out  1  write busy, always 0
- frame_start_sys  in  1  one-cycle frame pulse, already in clk_sys domain
- fifo_din  in  FIFO_W  FIFO push data
- fifo_push  in  1  FIFO push strobe
- fifo_full  out  1  FIFO full (back-pressure to source)

Behaviour:
- Clock and reset: one clock, clk_sys. rst_sys is synchronous, active high, and overrides everything else in the same cycle.
- Reset values:
  - rdata=0, fifo_full=0
  - frame_flag=0, frame_count=0, timer=0
  - timer_cmp='hFFFFFFFF
  - sticky bits=0, FIFO empty
- Writes: take effect only when cs && &wstrb (full-word writes). Partial-strobe writes are ignored. No wait states.
- Reads: on cs && rstrb, rdata updates on the next clk_sys edge (latency 1). rdata holds its value until the next read. Reads of unmapped indices return 0.
- Register map (index, byte offset):
  - 0 (0x00) ID: RO, returns HW_ID.
  - 1 (0x04) FRAME_FLAG: RO, bit0. Set by frame_start_sys.
  - 2 (0x08) FRAME_FLAG_CLR: WO, any write clears the flag. If the set and the clear arrive in the same cycle, the set wins.
  - 3 (0x0C) FRAME_COUNT: RO, increments on frame_start_sys and wraps at 2^32. A write clears it to 0; if a write and a frame pulse coincide, the result is 1.
  - 4 (0x10) TIMER: increments every cycle and wraps. A write loads wdata, and the count resumes from that value on the next cycle.
  - 5 (0x14) TIMER_CMP: RW.
  - 6 (0x18) STATUS bits:
    - bit0 fifo_empty
    - bit1 fifo_full
    - bit2 overflow (sticky)
    - bit3 timer_match (sticky)
    - [15:8] fifo count
    - other bits 0
    Bits 2 and 3 are write-1-to-clear. If a set event and a W1C occur in the same cycle, the set wins.
  - 7 (0x1C) FIFO_DATA: RO with pop-on-read.
    - Non-empty: returns {1'b1, zeros, data} and pops the entry.
    - Empty: returns 0 and leaves the FIFO unchanged.
- timer_match: set in the cycle timer==timer_cmp.
- FIFO:
  - Push while full: the data is dropped and overflow is set.
  - Push and pop in the same cycle when full: both are performed and the count is unchanged.
  - Push and pop in the same cycle when empty: push only; the pop returns 0.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_full is registered, consistent with count.
- Reset mid-read: the pending rdata is discarded and rdata=0.

Optional Feature:
- Macro: HWREG_IRQ_EN.
- When defined:
  - Adds output port irq (1 bit) and register IRQ_MASK at index 8 (0x20), RW, reset 0.
  - Mask bit0 enables frame_flag, bit1 fifo non-empty, bit2 timer_match.
  - irq is registered: irq = |(mask & sources), updated one cycle after any source or mask change.
- When undefined: no irq port; index 8 reads 0 and writes are ignored.

Decomposition:
- Package hwreg_pkg (localparams):
  - register indices and byte offsets
  - STATUS bit positions
  - IRQ_MASK bit positions
  - HW_ID default
  - The package is shared with software headers.
- One sub-module, fifo_sync: parameters DEPTH and W; ports push, pop, din, dout, empty, full, count; read data is combinational from the head entry.
- Register decode and counters stay in hwreg_resp.

Test Plan:
- ID/latency: cs=1, rstrb=1, addr=0 -> rdata='h49534C45 on the next edge; rdata stays stable over idle cycles.
- Frame flag: pulse frame_start_sys, read index 1 -> 1. Full-word write index 2 -> read 0. Pulse and clear in the same cycle -> read 1. FRAME_COUNT reads 2 after two pulses.
- Partial write: wstrb='b0011 to TIMER_CMP -> TIMER_CMP unchanged, reads 'hFFFFFFFF.
- Timer: write TIMER=100, TIMER_CMP=105 -> STATUS bit3=1 within 6 cycles. W1C with 'h8 -> bit3=0.
- FIFO: push 'h41..'h50 (16 entries) -> fifo_full=1, STATUS[15:8]=16. 17th push -> overflow=1. 16 reads of index 7 -> 'h80000041..'h80000050. 17th read -> 0, empty=1.
- With HWREG_IRQ_EN: IRQ_MASK='h2, push 'h33 -> irq=1. Read FIFO_DATA -> irq=0 one cycle after the pop.
